// File: rtl/instruction_fetch_unit.sv
// Program counter and fetch control feeding a 1-cycle registered instruction
// memory. Pairs each returned word with its PC, valid flag and fault flag.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] read_address,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        if_valid,
   output logic        if_fault,
   output logic [31:0] fetch_count
);

   // Highest legal word address; anything above it faults.
   localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

   logic [31:0] pc;
   logic [31:0] sel_addr;
   logic        hold;
   logic        out_of_range;

   // Hold only when the decoder stalls on a real word and no redirect overrides it.
   assign hold         = stall && if_valid && !redirect_valid;
   assign out_of_range = (sel_addr > LAST_WORD);

   // Select the fetch address: reset, redirect, held word, then sequential pc.
   always_comb begin
      sel_addr = pc;
      if (!rst_n) begin
         sel_addr = RESET_PC;
      end else if (redirect_valid) begin
         sel_addr = {redirect_target[31:2], 2'b00};
      end else if (stall && if_valid) begin
         sel_addr = if_pc;
      end
   end

   assign read_address = sel_addr;
   assign if_pc_plus4  = if_pc + 32'd4;

   // Fetch state update: reset, hold, or deliver/fault on the selected address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         if_pc       <= '0;
         if_valid    <= 1'b0;
         if_fault    <= 1'b0;
         fetch_count <= '0;
      end else if (!hold) begin
         if_pc <= sel_addr;
         if (out_of_range) begin
            // pc parks on the bad address so the fault repeats until redirect/reset.
            if_valid <= 1'b0;
            if_fault <= 1'b1;
            pc       <= sel_addr;
         end else begin
            if_valid    <= 1'b1;
            if_fault    <= 1'b0;
            pc          <= sel_addr + 32'd4;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios plus randomized stimulus, compared
// against a behavioural reference model of the fetch stage.
module tb_instruction_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int unsigned MEM_BYTES = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] read_address;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_valid;
   logic        if_fault;
   logic [31:0] fetch_count;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // reference model state
   longint unsigned m_next;
   longint unsigned m_pc;
   bit              m_valid;
   bit              m_fault;
   longint unsigned m_count;

   instruction_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .MEM_BYTES (MEM_BYTES)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .read_address    (read_address),
      .if_pc           (if_pc),
      .if_pc_plus4     (if_pc_plus4),
      .if_valid        (if_valid),
      .if_fault        (if_fault),
      .fetch_count     (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Address the model expects the unit to present this cycle.
   function automatic longint unsigned model_addr(bit r, bit s, bit rv, logic [31:0] rt);
      if (!r) return longint'(RESET_PC);
      if (rv) return longint'(rt) / 4 * 4;
      if (s && m_valid) return m_pc;
      return m_next;
   endfunction

   task automatic model_edge(bit r, bit s, bit rv, logic [31:0] rt);
      longint unsigned a;
      a = model_addr(r, s, rv, rt);
      if (!r) begin
         m_next = RESET_PC; m_pc = 0; m_valid = 0; m_fault = 0; m_count = 0;
      end else if (s && m_valid && !rv) begin
         // decoder busy: everything stays
      end else begin
         m_pc = a;
         if (a + 4 > MEM_BYTES) begin
            m_valid = 0; m_fault = 1; m_next = a;
         end else begin
            m_valid = 1; m_fault = 0;
            m_next  = (a + 4) % 64'h1_0000_0000;
            m_count = (m_count + 1) % 64'h1_0000_0000;
         end
      end
   endtask

   // One cycle: drive, check the combinational address, clock, check registers.
   task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rt);
      rst_n = r; stall = s; redirect_valid = rv; redirect_target = rt;
      #1;
      check("read_address", read_address, 32'(model_addr(r, s, rv, rt)));
      @(posedge clk);
      model_edge(r, s, rv, rt);
      @(negedge clk);
      check("if_pc", if_pc, 32'(m_pc));
      check("if_pc_plus4", if_pc_plus4, 32'((m_pc + 4) % 64'h1_0000_0000));
      check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      check("if_fault", {31'd0, if_fault}, {31'd0, m_fault});
      check("fetch_count", fetch_count, 32'(m_count));
   endtask

   initial begin
      m_next = RESET_PC; m_pc = 0; m_valid = 0; m_fault = 0; m_count = 0;
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      @(negedge clk);

      // reset and sequential run
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("rst_if_pc_plus4", if_pc_plus4, 32'd4);
      check("rst_count", fetch_count, 32'd0);
      step(1, 0, 0, 0);
      check("first_if_pc", if_pc, 32'd0);
      check("first_count", fetch_count, 32'd1);
      step(1, 0, 0, 0);
      check("second_if_pc", if_pc, 32'd4);

      // stall three cycles on if_pc = 4
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
      check("stall_count", fetch_count, 32'd2);
      check("stall_addr", read_address, 32'd4);
      step(1, 0, 0, 0);
      check("release_if_pc", if_pc, 32'd8);
      check("release_count", fetch_count, 32'd3);

      // redirect to 0x42 while stalled
      rst_n = 1; stall = 1; redirect_valid = 1; redirect_target = 32'h42;
      #1 check("redir_addr_now", read_address, 32'h40);
      step(1, 1, 1, 32'h42);
      check("redir_if_pc", if_pc, 32'h40);
      check("redir_plus4", if_pc_plus4, 32'h44);
      step(1, 0, 0, 0);

      // sequential run into the end of memory
      step(1, 0, 1, 32'hF8);
      step(1, 0, 0, 0);
      check("fc_valid", {31'd0, if_valid}, 32'd1);
      step(1, 0, 0, 0);
      check("fault_set", {31'd0, if_fault}, 32'd1);
      check("fault_if_pc", if_pc, 32'h100);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      check("fault_stuck_addr", read_address, 32'h100);
      step(1, 0, 1, 32'h0);
      check("fault_clear", {31'd0, if_fault}, 32'd0);
      check("fault_clear_pc", if_pc, 32'd0);

      // reset mid-run with stall and redirect
      step(1, 0, 0, 0);
      step(0, 1, 1, 32'h80);
      check("midrst_valid", {31'd0, if_valid}, 32'd0);
      check("midrst_count", fetch_count, 32'd0);
      // stall ignored while nothing valid is held
      step(1, 1, 0, 0);
      check("stall_ignored", {31'd0, if_valid}, 32'd1);
      check("stall_ignored_pc", if_pc, RESET_PC);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         bit r, s, rv;
         logic [31:0] rt;
         r  = ($urandom_range(0, 49) != 0);
         s  = ($urandom_range(0, 2) == 0);
         rv = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       rt = $urandom;
            1:       rt = 32'($urandom_range(32'hE8, 32'h10F));
            2:       rt = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            default: rt = 32'($urandom_range(0, 255));
         endcase
         step(r, s, rv, rt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Program-counter and fetch-control stage directly upstream of `Instruction_memory`. It generates `read_address` for the instruction memory, which has a 1-cycle registered read and returns big-endian bytes. It pairs each returned `instruction` with its PC and a valid flag for the decoder. It also handles decoder stalls, branch/jump redirects, out-of-range fetch faults and a delivered-instruction counter.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `MEM_BYTES`, 256: byte size of the instruction memory; a word fetch at address A is legal iff A <= MEM_BYTES-4.

- `clk`  in  1  rising-edge clock, shared with `Instruction_memory`.
- `rst_n`  in  1  reset, synchronous and active-low.
- `stall`  in  1  decoder cannot accept; hold the current fetch.
- `redirect_valid`  in  1  take `redirect_target` this cycle.
- `redirect_target`  in  32  branch/jump target byte address.
- `read_address`  out  32  to `Instruction_memory.read_address`; combinational.
- `if_pc`  out  32  address of the word currently on `instruction`.
- `if_pc_plus4`  out  32  `if_pc + 4`, mod 2^32.
- `if_valid`  out  1  `instruction` / `if_pc` hold a real fetch.
- `if_fault`  out  1  last fetch was out of range.
- `fetch_count`  out  32  number of new valid fetches delivered.

## Operation
- Internal state: `pc` (next sequential fetch address), `if_pc`, `if_valid`, `if_fault`, `fetch_count`.
- Selected address `A` is combinational, highest priority first:
  - `!rst_n` → `RESET_PC`
  - `redirect_valid` → `{redirect_target[31:2], 2'b00}` (low two bits are ignored)
  - `stall && if_valid` → `if_pc` (the memory re-reads the held word, so `instruction` stays stable)
  - otherwise → `pc`
- `read_address = A` at all times.
- Per edge, in priority order:
  - Reset (`rst_n = 0`):
    - `pc <= RESET_PC`, `if_pc <= 0`, `if_valid <= 0`, `if_fault <= 0`, `fetch_count <= 0`.
  - Hold (`stall && if_valid && !redirect_valid`):
    - All state unchanged.
  - Fetch (any other case):
    - `if_pc <= A`.
    - If `A > MEM_BYTES-4` (unsigned): `if_valid <= 0`, `if_fault <= 1`, `pc <= A`. The fault repeats every cycle until a redirect or reset.
    - Else: `if_valid <= 1`, `if_fault <= 0`, `pc <= A + 4` (wraps mod 2^32), `fetch_count <= fetch_count + 1` (wraps).
- `stall` while `if_valid = 0` is ignored: the unit keeps fetching.
- Redirect takes the target in the same cycle, with no bubble. The word on `instruction` during the redirect cycle is replaced at the next edge; squashing it is the decoder's job.
- Redirect with stall: redirect wins, and the held word is discarded.

## Timing
- All outputs are registered except `read_address` (combinational from `rst_n`, `redirect_*`, `stall` and state) and `if_pc_plus4` (combinational from `if_pc`).
- Reset values: `if_pc = 0`, `if_pc_plus4 = 4`, `if_valid = 0`, `if_fault = 0`, `fetch_count = 0`, `read_address = RESET_PC`.
- Latency:
  - Address `A` presented before edge N produces `instruction`, `if_pc = A` and `if_valid` together after edge N (1 cycle).
  - The first valid word appears after the first edge with `rst_n = 1`.
- Throughput: one word per cycle when not stalled.
- Reset mid-operation: reset overrides stall and redirect, and takes effect at that edge.

## Test plan
- Reset/run, `RESET_PC = 0`, memory words 0x014B4822 at 0 and 0x014B6820 at 4:
  - Hold `rst_n` low 2 cycles, then release.
  - `read_address` sequence 0, 4, 8.
  - After edge 1: `if_pc = 0`, `instruction = 0x014B4822`, `if_valid = 1`, `fetch_count = 1`.
  - After edge 2: `if_pc = 4`, `instruction = 0x014B6820`.
- Stall 3 cycles while `if_pc = 4`:
  - `read_address = 4` throughout; `instruction` stays 0x014B6820; `fetch_count` stays 2.
  - After release: `if_pc = 8`, `fetch_count = 3`.
- Redirect to 0x42 during run, with `stall = 1`:
  - `read_address = 0x40` in the same cycle.
  - Next: `if_pc = 0x40`, `if_pc_plus4 = 0x44`, `if_valid = 1`; following `read_address = 0x44`.
- Sequential run from 0xF8:
  - 0xF8 and 0xFC valid.
  - At 0x100: `if_valid = 0`, `if_fault = 1`, `read_address` stuck at 0x100, `fetch_count` frozen.
  - Then redirect to 0 → `if_fault = 0`, `if_valid = 1`, `if_pc = 0`.
- Reset mid-run with `stall = 1` and `redirect_valid = 1`, `rst_n` low 1 cycle:
  - `read_address = RESET_PC` during reset.
  - After the edge: `if_valid = 0`, `if_fault = 0`, `fetch_count = 0`.
  - Next edge: `if_pc = RESET_PC`, `if_valid = 1`.
- Stall while `if_valid = 0` (first cycle after reset release):
  - Stall is ignored: `if_pc = RESET_PC`, `if_valid = 1` after the edge.
